// File: rtl/oled_sched_pkg.sv
// rtl/oled_sched_pkg.sv - shared types and constants for the OLED glyph write scheduler
package oled_sched_pkg;

  localparam int NUM_DISPLAYS = 4;
  localparam int GLYPH_W      = 5;
  localparam int I2C_ADDR_W   = 7;
  // Consecutive failures tolerated before a request is dropped (retry build only)
  localparam int RETRY_LIMIT  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } sched_state_t;

endpackage

// File: rtl/oled_glyph_sched_rr_arbiter4.sv
// rtl/oled_glyph_sched_rr_arbiter4.sv - combinational 4-way round-robin pick starting after the last grant
module rr_arbiter4
  import oled_sched_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_grant,
  output logic       o_valid
);

  logic [1:0] w_idx;

  // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); the first requester found wins
  always_comb begin
    o_grant = 2'd0;
    o_valid = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= NUM_DISPLAYS; k++) begin
      w_idx = i_ptr + 2'(k);
      if (!o_valid && i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_glyph_sched.sv
// rtl/oled_glyph_sched.sv - latches per-display glyph requests and serialises them onto one I2C writer (optional OLED_SCHED_RETRY_EN)
module oled_glyph_sched
  import oled_sched_pkg::*;
#(
  parameter logic [6:0]  ADDR0          = 7'h3C,
  parameter logic [6:0]  ADDR1          = 7'h3D,
  parameter logic [6:0]  ADDR2          = 7'h3E,
  parameter logic [6:0]  ADDR3          = 7'h3F,
  parameter int unsigned GAP_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] set,
  input  logic [4:0] glyph,
  output logic       wr_start,
  output logic [6:0] wr_addr,
  output logic [4:0] wr_word,
  input  logic       wr_done,
  input  logic       wr_nack,
  output logic [3:0] pending,
  output logic       busy,
  output logic [3:0] err
);

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  sched_state_t                    r_state;
  logic [1:0]                      r_ptr;
  logic [NUM_DISPLAYS-1:0]         r_pend;
  logic [GLYPH_W-1:0]              r_glyph_q [NUM_DISPLAYS];
  logic [NUM_DISPLAYS-1:0]         r_err;
  logic [31:0]                     r_cnt;
  logic                            r_wr_start;
  logic [I2C_ADDR_W-1:0]           r_wr_addr;
  logic [GLYPH_W-1:0]              r_wr_word;
`ifdef OLED_SCHED_RETRY_EN
  logic [1:0]                      r_retry [NUM_DISPLAYS];
`endif

  logic [1:0] w_grant;
  logic       w_valid;
  logic       w_timeout;
  logic       w_end;
  logic       w_fail;

  rr_arbiter4 u_arb (
    .i_req   (r_pend),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  // A done pulse in the same cycle as the timeout edge counts as a normal completion
  assign w_timeout = !wr_done && (r_cnt == TO_LAST);
  assign w_end     = wr_done || w_timeout;
  assign w_fail    = (wr_done && wr_nack) || w_timeout;

  function automatic logic [6:0] addr_of(input logic [1:0] g);
    case (g)
      2'd0:    addr_of = ADDR0;
      2'd1:    addr_of = ADDR1;
      2'd2:    addr_of = ADDR2;
      default: addr_of = ADDR3;
    endcase
  endfunction

  // Scheduler FSM plus request slots; the set capture is last so a fresh request beats a grant clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd3;
      r_pend     <= '0;
      r_err      <= '0;
      r_cnt      <= '0;
      r_wr_start <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_word  <= '0;
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        r_glyph_q[i] <= '0;
`ifdef OLED_SCHED_RETRY_EN
        r_retry[i]   <= '0;
`endif
      end
    end else begin
      r_wr_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_ptr           <= w_grant;
            r_wr_addr       <= addr_of(w_grant);
            r_wr_word       <= r_glyph_q[w_grant];
            r_pend[w_grant] <= 1'b0;
            r_wr_start      <= 1'b1;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_end) begin
            r_cnt   <= '0;
            r_state <= GAP;
            if (w_fail) begin
`ifdef OLED_SCHED_RETRY_EN
              if (r_retry[r_ptr] == 2'(RETRY_LIMIT - 1)) begin
                r_err[r_ptr]   <= 1'b1;
                r_retry[r_ptr] <= '0;
              end else begin
                r_retry[r_ptr] <= r_retry[r_ptr] + 2'd1;
                r_pend[r_ptr]  <= 1'b1;
              end
`else
              r_err[r_ptr] <= 1'b1;
`endif
            end else begin
`ifdef OLED_SCHED_RETRY_EN
              r_retry[r_ptr] <= '0;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
      for (int i = 0; i < NUM_DISPLAYS; i++) begin
        if (set[i]) begin
          r_pend[i]    <= 1'b1;
          r_glyph_q[i] <= glyph;
`ifdef OLED_SCHED_RETRY_EN
          r_retry[i]   <= '0;
`endif
        end
      end
    end
  end

  assign wr_start = r_wr_start;
  assign wr_addr  = r_wr_addr;
  assign wr_word  = r_wr_word;
  assign pending  = r_pend;
  assign err      = r_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_oled_glyph_sched.sv
// tb/tb_oled_glyph_sched.sv - directed self-checking bench for oled_glyph_sched
module tb_oled_glyph_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] set;
  logic [4:0] glyph;
  logic       wr_start;
  logic [6:0] wr_addr;
  logic [4:0] wr_word;
  logic       wr_done;
  logic       wr_nack;
  logic [3:0] pending;
  logic       busy;
  logic [3:0] err;

  int checks   = 0;
  int errors   = 0;
  int n_starts = 0;
  int base;
  bit found;

  oled_glyph_sched #(
    .GAP_CYCLES     (50),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set      (set),
    .glyph    (glyph),
    .wr_start (wr_start),
    .wr_addr  (wr_addr),
    .wr_word  (wr_word),
    .wr_done  (wr_done),
    .wr_nack  (wr_nack),
    .pending  (pending),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count every cycle in which wr_start is high
  always @(posedge clk) begin
    #1;
    if (wr_start) n_starts++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set   = 4'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_start(output bit f);
    f = 1'b0;
    for (int i = 0; i < 200 && !f; i++) begin
      tick();
      if (wr_start) f = 1'b1;
    end
  endtask

  task automatic wait_idle();
    bit f;
    f = 1'b0;
    for (int i = 0; i < 200 && !f; i++) begin
      tick();
      if (!busy) f = 1'b1;
    end
    check("idle_reached", 32'(f), 32'd1);
  endtask

  task automatic do_txn(input logic [6:0] a, input logic [4:0] w, input bit nack, input int delay);
    bit f;
    wait_start(f);
    check("start_seen", 32'(f), 32'd1);
    check("txn_addr", 32'(wr_addr), 32'(a));
    check("txn_word", 32'(wr_word), 32'(w));
    repeat (delay) tick();
    check("addr_hold", 32'(wr_addr), 32'(a));
    wr_done = 1'b1;
    wr_nack = nack;
    tick();
    wr_done = 1'b0;
    wr_nack = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    set     = 4'd0;
    glyph   = 5'd0;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    do_reset();

    // Reset state
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start", 32'(wr_start), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_word", 32'(wr_word), 32'd0);

    // Single request: wr_start two edges after the set strobe
    set = 4'b0100; glyph = 5'd17;
    tick();
    set = 4'd0;
    check("single_pend", 32'(pending), 32'b0100);
    check("single_nostart", 32'(wr_start), 32'd0);
    tick();
    check("single_start", 32'(wr_start), 32'd1);
    check("single_addr", 32'(wr_addr), 32'h3E);
    check("single_word", 32'(wr_word), 32'd17);
    check("single_pend_clr", 32'(pending), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_pulse_len", 32'(wr_start), 32'd0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    base = n_starts;
    repeat (50) tick();
    check("single_gap_quiet", 32'(n_starts - base), 32'd0);
    wait_idle();
    check("single_end_pend", 32'(pending), 32'd0);
    check("single_end_err", 32'(err), 32'd0);

    // Round robin from reset: 0,1,2,3
    do_reset();
    set = 4'b1111; glyph = 5'd9;
    tick();
    set = 4'd0;
    check("rr_pend", 32'(pending), 32'b1111);
    do_txn(7'h3C, 5'd9, 1'b0, 10);
    do_txn(7'h3D, 5'd9, 1'b0, 10);
    do_txn(7'h3E, 5'd9, 1'b0, 10);
    do_txn(7'h3F, 5'd9, 1'b0, 10);

    // Overwrite during the gap: latest glyph wins
    set = 4'b0010; glyph = 5'd3;
    tick();
    glyph = 5'd7;
    tick();
    set = 4'd0;
    check("ovw_pend", 32'(pending), 32'b0010);
    wait_start(found);
    check("ovw_start", 32'(found), 32'd1);
    check("ovw_addr", 32'(wr_addr), 32'h3D);
    check("ovw_word", 32'(wr_word), 32'd7);
    tick();
    // Re-queue while in flight
    set = 4'b0010; glyph = 5'd12;
    tick();
    set = 4'd0;
    check("requeue_pend", 32'(pending), 32'b0010);
    check("inflight_word", 32'(wr_word), 32'd7);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    do_txn(7'h3D, 5'd12, 1'b0, 3);
    wait_idle();
    check("requeue_end_pend", 32'(pending), 32'd0);

    // Set in the same cycle as the grant: old glyph sent, new one stays pending
    set = 4'b0001; glyph = 5'd5;
    tick();
    glyph = 5'd6;
    tick();
    set = 4'd0;
    check("coll_start", 32'(wr_start), 32'd1);
    check("coll_word", 32'(wr_word), 32'd5);
    check("coll_pend", 32'(pending), 32'b0001);
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    do_txn(7'h3C, 5'd6, 1'b0, 2);
    wait_idle();
    check("coll_end_pend", 32'(pending), 32'd0);

`ifndef OLED_SCHED_RETRY_EN
    // Nack: sticky error, no retry
    do_reset();
    set = 4'b0001; glyph = 5'd1;
    tick();
    set = 4'd0;
    do_txn(7'h3C, 5'd1, 1'b1, 2);
    check("nack_err", 32'(err), 32'b0001);
    check("nack_pend", 32'(pending), 32'd0);
    base = n_starts;
    wait_idle();
    check("nack_noretry", 32'(n_starts - base), 32'd0);

    // Timeout after 20 cycles in flight
    set = 4'b1000; glyph = 5'd4;
    tick();
    set = 4'd0;
    wait_start(found);
    check("to_start", 32'(found), 32'd1);
    repeat (20) tick();
    check("to_err_before", 32'(err), 32'b0001);
    tick();
    check("to_err_after", 32'(err), 32'b1001);
    check("to_busy_gap", 32'(busy), 32'd1);
    base = n_starts;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    wait_idle();
    check("to_late_done_ignored", 32'(err), 32'b1001);
    check("to_end_pend", 32'(pending), 32'd0);
    check("to_noretry", 32'(n_starts - base), 32'd0);
`else
    // Three nacks then drop with error
    do_reset();
    base = n_starts;
    set = 4'b0100; glyph = 5'd8;
    tick();
    set = 4'd0;
    do_txn(7'h3E, 5'd8, 1'b1, 2);
    check("retry1_pend", 32'(pending), 32'b0100);
    check("retry1_err", 32'(err), 32'd0);
    do_txn(7'h3E, 5'd8, 1'b1, 2);
    do_txn(7'h3E, 5'd8, 1'b1, 2);
    check("retry3_err", 32'(err), 32'b0100);
    check("retry3_pend", 32'(pending), 32'd0);
    wait_idle();
    check("retry3_starts", 32'(n_starts - base), 32'd3);

    // One nack then success
    do_reset();
    base = n_starts;
    set = 4'b0100; glyph = 5'd8;
    tick();
    set = 4'd0;
    do_txn(7'h3E, 5'd8, 1'b1, 2);
    do_txn(7'h3E, 5'd8, 1'b0, 2);
    wait_idle();
    check("retry_ok_starts", 32'(n_starts - base), 32'd2);
    check("retry_ok_err", 32'(err), 32'd0);
    set = 4'b0001; glyph = 5'd1;
    tick();
    set = 4'd0;
    do_txn(7'h3C, 5'd1, 1'b1, 2);
    do_txn(7'h3C, 5'd1, 1'b1, 2);
    do_txn(7'h3C, 5'd1, 1'b1, 2);
    wait_idle();
    check("retry_err0", 32'(err), 32'b0001);
`endif

    // Reset in the middle of a transaction
    set = 4'b0100; glyph = 5'd2;
    tick();
    set = 4'd0;
    wait_start(found);
    check("mid_start", 32'(found), 32'd1);
    tick();
    set = 4'b0001; glyph = 5'd3;
    tick();
    set = 4'd0;
    tick();
    check("mid_pend_before", 32'(pending), 32'b0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_pend", 32'(pending), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_start_clr", 32'(wr_start), 32'd0);
    base = n_starts;
    repeat (5) tick();
    check("mid_quiet", 32'(n_starts - base), 32'd0);
    set = 4'b1000; glyph = 5'd21;
    tick();
    set = 4'd0;
    do_txn(7'h3F, 5'd21, 1'b0, 3);
    wait_idle();
    check("mid_after_err", 32'(err), 32'd0);
    check("mid_after_pend", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
